// File: rtl/arm_instr_encoder_pkg.sv
// arm_enc_pkg: op/state enums and the ARM field-set to instruction-word packer shared by the encoder and its benches.
package arm_enc_pkg;
  typedef enum logic [1:0] {OP_DP, OP_MEM, OP_BR, OP_ILL} op_e;
  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_e;
  localparam logic [3:0] COND_AL = 4'hE;
  // Returns {legal, word}; branches require funct[5] (I) set.
  function automatic logic [32:0] encode_word(input logic [3:0] cond, input op_e op, input logic [5:0] funct,
                                              input logic [3:0] rn, rd, input logic [11:0] src2, input logic [23:0] imm24);
    logic legal;
    legal = op == OP_DP || op == OP_MEM || (op == OP_BR && funct[5]);
    return {legal, op == OP_BR ? {cond, 2'b10, 1'b1, funct[4], imm24} : {cond, op, funct, rn, rd, src2}};
  endfunction
endpackage

// File: rtl/arm_instr_encoder_if.sv
// arm_instr_encoder_if: valid/ready field-set channel into the instruction encoder.
interface arm_instr_encoder_if;
  logic in_valid, in_ready;
  logic [3:0] cond, rn, rd;
  logic [1:0] op;
  logic [5:0] funct;
  logic [11:0] src2;
  logic [23:0] imm24;
  modport master(output in_valid, cond, op, funct, rn, rd, src2, imm24, input in_ready);
  modport slave(input in_valid, cond, op, funct, rn, rd, src2, imm24, output in_ready);
endinterface

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder: packs ARM field sets into words and writes them sequentially into imem.
// Define ARM_ENC_CHECKSUM_EN to add an XOR checksum of every written word.
module arm_instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  arm_instr_encoder_if.slave bus,
  output logic mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [ADDR_W:0] count,
  output logic full,
  output logic error
`ifdef ARM_ENC_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
  state_e state;
  logic [32:0] enc;
  assign enc = encode_word(bus.cond, op_e'(bus.op), bus.funct, bus.rn, bus.rd, bus.src2, bus.imm24);
  assign bus.in_ready = state == IDLE;
  assign full = state == FULL;
  // clear aborts a write in the very cycle it is raised
  assign mem_we = state == WRITE && !clear;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      mem_addr <= BASE_ADDR;
      mem_wdata <= '0;
      count <= '0;
      error <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      mem_addr <= BASE_ADDR;
      count <= '0;
      error <= 1'b0;
    end else
      case (state)
        IDLE:
          if (bus.in_valid) begin
            if (enc[32]) begin
              mem_wdata <= enc[31:0];
              state <= WRITE;
            end else
              error <= 1'b1;
          end
        WRITE: begin
          count <= count + 1'b1;
          // the address parks on the last word once the region is exhausted
          if (count == LAST)
            state <= FULL;
          else begin
            state <= IDLE;
            mem_addr <= mem_addr + 32'd4;
          end
        end
        default: ;
      endcase
`ifdef ARM_ENC_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)
      checksum <= '0;
    else if (clear)
      checksum <= '0;
    else if (mem_we)
      checksum <= checksum ^ mem_wdata;
`endif
endmodule
